// File: rtl/mem_bus_arbiter.sv
// Data-memory bus arbiter: grants one of NUM_MST masters and muxes it onto the slave bus.
// Optional grant-hold timeout is compiled in when the macro ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
    parameter int unsigned NUM_MST    = 3,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned MAX_HOLD   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_MST-1:0]   mst_req,
    output logic [NUM_MST-1:0]   mst_grant,
    input  logic [8*NUM_MST-1:0] mst_addr,
    input  logic [NUM_MST-1:0]   mst_wr,
    input  logic [NUM_MST-1:0]   mst_rd,
    input  logic [8*NUM_MST-1:0] mst_wdata,
    output logic [7:0]           slv_addr,
    output logic                 slv_wr,
    output logic                 slv_rd,
    output logic [7:0]           slv_wdata,
    output logic                 bus_busy,
    output logic [1:0]           owner,
    output logic                 timeout_err
);
    localparam int unsigned IDX_W = 2;
    localparam int unsigned VEC_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    if (NUM_MST < 2 || NUM_MST > 4 || MAX_HOLD == 0) begin : g_param_check
        $error("mem_bus_arbiter: NUM_MST must be 2..4 and MAX_HOLD nonzero");
    end

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (32'(i) + 32'd1 >= NUM_MST) return '0;
        return i + IDX_W'(1);
    endfunction

    state_e             state_q, state_d;
    logic [NUM_MST-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;

    logic [VEC_W-1:0]   cand;
    logic [VEC_W-1:0]   onehot;
    logic [IDX_W-1:0]   scan_base;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               owner_req;
    logic               take;
    logic               hold_expired;
    int unsigned        idx_sum;

    // Candidates exclude the current owner, so a releasing master never wins its own re-arbitration
    always_comb begin
        cand      = VEC_W'(mst_req & ~grant_q);
        owner_req = |(mst_req & grant_q);
        scan_base = (FIXED_PRIO != 0) ? '0 : ptr_q;
        win_found = 1'b0;
        win_idx   = '0;
        idx_sum   = '0;
        for (int k = int'(NUM_MST) - 1; k >= 0; k--) begin
            idx_sum = 32'(scan_base) + 32'(k);
            if (idx_sum >= NUM_MST) idx_sum = idx_sum - NUM_MST;
            if (cand[IDX_W'(idx_sum)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx_sum);
            end
        end
        onehot = VEC_W'(1) << win_idx;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             tmo_q, tmo_d;

    // Expires on the cycle whose edge brings the count to MAX_HOLD, but only under contention
    assign hold_expired = (hold_q >= CNT_W'(MAX_HOLD - 1)) && (|cand);
    assign timeout_err  = tmo_q;
`else
    assign hold_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        take    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
        tmo_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: take = win_found;
            OWNED: begin
`ifdef ARB_TIMEOUT_EN
                if (hold_q < CNT_W'(MAX_HOLD)) hold_d = hold_q + CNT_W'(1);
                if (owner_req && hold_expired) tmo_d = 1'b1;
`endif
                if (!owner_req || hold_expired) begin
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        owner_d = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        if (take) begin
            state_d = OWNED;
            grant_d = onehot[NUM_MST-1:0];
            owner_d = win_idx;
            ptr_d   = wrap_inc(win_idx);
            busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            tmo_q  <= tmo_d;
        end
    end
`endif

    // Slave bus follows the registered one-hot grant; zero when nobody owns it
    always_comb begin
        slv_addr  = '0;
        slv_wr    = 1'b0;
        slv_rd    = 1'b0;
        slv_wdata = '0;
        for (int i = 0; i < int'(NUM_MST); i++) begin
            if (grant_q[i]) begin
                slv_addr  = slv_addr | mst_addr[8*i +: 8];
                slv_wr    = slv_wr | mst_wr[i];
                slv_rd    = slv_rd | mst_rd[i];
                slv_wdata = slv_wdata | mst_wdata[8*i +: 8];
            end
        end
    end

    assign mst_grant = grant_q;
    assign owner     = owner_q;
    assign bus_busy  = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_mem_bus_arbiter;
    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [2:0]  rd;
    logic [23:0] addr;
    logic [23:0] wdata;

    logic [2:0]  rr_grant, fp_grant;
    logic [7:0]  rr_slv_addr, fp_slv_addr, rr_slv_wdata, fp_slv_wdata;
    logic        rr_slv_wr, fp_slv_wr, rr_slv_rd, fp_slv_rd;
    logic        rr_busy, fp_busy, rr_tmo, fp_tmo;
    logic [1:0]  rr_owner, fp_owner;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_arbiter #(.NUM_MST(3), .FIXED_PRIO(0), .MAX_HOLD(4)) dut_rr (
        .clk(clk), .rst(rst), .mst_req(req), .mst_grant(rr_grant),
        .mst_addr(addr), .mst_wr(wr), .mst_rd(rd), .mst_wdata(wdata),
        .slv_addr(rr_slv_addr), .slv_wr(rr_slv_wr), .slv_rd(rr_slv_rd),
        .slv_wdata(rr_slv_wdata), .bus_busy(rr_busy), .owner(rr_owner),
        .timeout_err(rr_tmo)
    );

    mem_bus_arbiter #(.NUM_MST(3), .FIXED_PRIO(1), .MAX_HOLD(4)) dut_fp (
        .clk(clk), .rst(rst), .mst_req(req), .mst_grant(fp_grant),
        .mst_addr(addr), .mst_wr(wr), .mst_rd(rd), .mst_wdata(wdata),
        .slv_addr(fp_slv_addr), .slv_wr(fp_slv_wr), .slv_rd(fp_slv_rd),
        .slv_wdata(fp_slv_wdata), .bus_busy(fp_busy), .owner(fp_owner),
        .timeout_err(fp_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] oh2idx(input logic [2:0] g);
        case (g)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; wr = '0; rd = '0; addr = '0; wdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 3'b111; wr = 3'b111; rd = 3'b111;
        addr = 24'hA5A5A5; wdata = 24'h5A5A5A;
        tick();
        tick();
        n_tests++; if (rr_grant !== 3'b000) begin n_fail++; $display("FAIL reset_rr_grant: got %b want 000", rr_grant); end
        n_tests++; if (fp_grant !== 3'b000) begin n_fail++; $display("FAIL reset_fp_grant: got %b want 000", fp_grant); end
        n_tests++; if (rr_busy !== 1'b0 || rr_owner !== 2'd0) begin n_fail++; $display("FAIL reset_busy_owner: got %b/%0d want 0/0", rr_busy, rr_owner); end
        n_tests++; if ({rr_slv_addr, rr_slv_wdata, rr_slv_wr, rr_slv_rd} !== 18'h0) begin n_fail++; $display("FAIL reset_slave_bus: got %h/%h/%b/%b want all 0", rr_slv_addr, rr_slv_wdata, rr_slv_wr, rr_slv_rd); end
        n_tests++; if (rr_tmo !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", rr_tmo); end
        rst = 1'b0;
        clear_inputs();
        tick();
        n_tests++; if (rr_grant !== 3'b000 || rr_slv_addr !== 8'h00) begin n_fail++; $display("FAIL idle_no_req: got %b/%h want 000/00", rr_grant, rr_slv_addr); end
    endtask

    task automatic test_single();
        req = 3'b010; wr = 3'b010;
        addr[15:8] = 8'h80; wdata[15:8] = 8'h11;
        #1;
        n_tests++; if (rr_slv_addr !== 8'h00 || rr_slv_wr !== 1'b0) begin n_fail++; $display("FAIL single_pre_grant_bus: got %h/%b want 00/0", rr_slv_addr, rr_slv_wr); end
        tick();
        n_tests++; if (rr_grant !== 3'b010) begin n_fail++; $display("FAIL single_grant: got %b want 010", rr_grant); end
        n_tests++; if (rr_owner !== 2'd1 || rr_busy !== 1'b1) begin n_fail++; $display("FAIL single_owner_busy: got %0d/%b want 1/1", rr_owner, rr_busy); end
        n_tests++; if (rr_slv_addr !== 8'h80 || rr_slv_wdata !== 8'h11 || rr_slv_wr !== 1'b1) begin n_fail++; $display("FAIL single_slave_bus: got %h/%h/%b want 80/11/1", rr_slv_addr, rr_slv_wdata, rr_slv_wr); end
        req = 3'b000;
        tick();
        n_tests++; if (rr_grant !== 3'b000 || rr_busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b/%b want 000/0", rr_grant, rr_busy); end
        n_tests++; if (rr_slv_addr !== 8'h00 || rr_slv_wr !== 1'b0 || rr_slv_wdata !== 8'h00) begin n_fail++; $display("FAIL single_idle_bus: got %h/%b/%h want 00/0/00", rr_slv_addr, rr_slv_wr, rr_slv_wdata); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [2:0] req_tbl [8] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011, 3'b000};
        logic [2:0] exp_tbl [8] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b000};
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            req = req_tbl[k];
            tick();
            n_tests++; if (rr_grant !== exp_tbl[k]) begin n_fail++; $display("FAIL rr_grant step %0d: got %b want %b", k, rr_grant, exp_tbl[k]); end
            n_tests++; if (rr_owner !== oh2idx(exp_tbl[k]) || rr_busy !== (exp_tbl[k] != 3'b000)) begin n_fail++; $display("FAIL rr_owner_busy step %0d: got %0d/%b want %0d/%b", k, rr_owner, rr_busy, oh2idx(exp_tbl[k]), exp_tbl[k] != 3'b000); end
        end
        clear_inputs();
    endtask

    task automatic test_fixed_prio();
        logic [2:0] req_tbl [9] = '{3'b100, 3'b110, 3'b110, 3'b010, 3'b000, 3'b100, 3'b111, 3'b011, 3'b000};
        logic [2:0] exp_tbl [9] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b000, 3'b100, 3'b100, 3'b001, 3'b000};
        clear_inputs();
        tick();
        for (int k = 0; k < 9; k++) begin
            req = req_tbl[k];
            tick();
            n_tests++; if (fp_grant !== exp_tbl[k]) begin n_fail++; $display("FAIL fp_grant step %0d: got %b want %b", k, fp_grant, exp_tbl[k]); end
            n_tests++; if (fp_owner !== oh2idx(exp_tbl[k])) begin n_fail++; $display("FAIL fp_owner step %0d: got %0d want %0d", k, fp_owner, oh2idx(exp_tbl[k])); end
        end
        clear_inputs();
    endtask

    task automatic test_hold_multi();
        logic wr_tbl [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic rd_tbl [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        addr  = {8'h00, 8'h55, 8'hFF};
        wdata = {8'h00, 8'hAA, 8'h3C};
        wr = 3'b010; rd = 3'b010;
        req = 3'b011;
        tick();
        n_tests++; if (rr_grant !== 3'b001) begin n_fail++; $display("FAIL hold_first_grant: got %b want 001", rr_grant); end
        for (int c = 0; c < 5; c++) begin
            wr[0] = wr_tbl[c];
            rd[0] = rd_tbl[c];
            #1;
            n_tests++; if (rr_slv_wr !== wr_tbl[c] || rr_slv_rd !== rd_tbl[c]) begin n_fail++; $display("FAIL hold_wr_rd cycle %0d: got %b/%b want %b/%b", c + 1, rr_slv_wr, rr_slv_rd, wr_tbl[c], rd_tbl[c]); end
            n_tests++; if (rr_slv_addr !== 8'hFF || rr_slv_wdata !== 8'h3C) begin n_fail++; $display("FAIL hold_addr_data cycle %0d: got %h/%h want FF/3C", c + 1, rr_slv_addr, rr_slv_wdata); end
            tick();
            n_tests++; if (rr_grant !== 3'b001) begin n_fail++; $display("FAIL hold_grant cycle %0d: got %b want 001", c + 1, rr_grant); end
        end
        req = 3'b010; wr[0] = 1'b0; rd[0] = 1'b0;
        tick();
        n_tests++; if (rr_grant !== 3'b010 || rr_busy !== 1'b1) begin n_fail++; $display("FAIL hold_handover: got %b/%b want 010/1", rr_grant, rr_busy); end
        n_tests++; if (rr_slv_addr !== 8'h55 || rr_slv_wr !== 1'b1) begin n_fail++; $display("FAIL hold_handover_bus: got %h/%b want 55/1", rr_slv_addr, rr_slv_wr); end
        clear_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        tick();
        req = 3'b010; wr = 3'b010; rd = 3'b010; addr[15:8] = 8'h42;
        tick();
        n_tests++; if (rr_grant !== 3'b010 || rr_slv_wr !== 1'b1 || rr_slv_rd !== 1'b1) begin n_fail++; $display("FAIL areset_pre_owner: got %b/%b/%b want 010/1/1", rr_grant, rr_slv_wr, rr_slv_rd); end
        #3;
        rst = 1'b1;
        #1;
        n_tests++; if (rr_grant !== 3'b000 || rr_busy !== 1'b0) begin n_fail++; $display("FAIL areset_grant_drop: got %b/%b want 000/0", rr_grant, rr_busy); end
        n_tests++; if (rr_slv_wr !== 1'b0 || rr_slv_rd !== 1'b0 || rr_slv_addr !== 8'h00) begin n_fail++; $display("FAIL areset_bus_drop: got %b/%b/%h want 0/0/00", rr_slv_wr, rr_slv_rd, rr_slv_addr); end
        req = 3'b111;
        tick();
        n_tests++; if (rr_grant !== 3'b000) begin n_fail++; $display("FAIL areset_req_ignored: got %b want 000", rr_grant); end
        rst = 1'b0;
        tick();
        n_tests++; if (rr_grant !== 3'b001 || fp_grant !== 3'b001) begin n_fail++; $display("FAIL areset_restart: got rr %b fp %b want 001", rr_grant, fp_grant); end
        clear_inputs();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [2:0] exp_tbl [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b100};
        logic       tmo_tbl [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        req = 3'b101;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++; if (rr_grant !== exp_tbl[k] || rr_tmo !== tmo_tbl[k]) begin n_fail++; $display("FAIL timeout step %0d: got %b/%b want %b/%b", k, rr_grant, rr_tmo, exp_tbl[k], tmo_tbl[k]); end
        end
        apply_reset();
        req = 3'b001;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++; if (rr_grant !== 3'b001 || rr_tmo !== 1'b0) begin n_fail++; $display("FAIL timeout_uncontended step %0d: got %b/%b want 001/0", k, rr_grant, rr_tmo); end
        end
        req = 3'b101;
        tick();
        n_tests++; if (rr_grant !== 3'b100 || rr_tmo !== 1'b1) begin n_fail++; $display("FAIL timeout_saturated: got %b/%b want 100/1", rr_grant, rr_tmo); end
        clear_inputs();
        tick();
    endtask
`else
    task automatic test_timeout();
        apply_reset();
        req = 3'b101;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++; if (rr_grant !== 3'b001 || rr_tmo !== 1'b0) begin n_fail++; $display("FAIL no_timeout step %0d: got %b/%b want 001/0", k, rr_grant, rr_tmo); end
        end
        clear_inputs();
        tick();
    endtask
`endif

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_prio();
        test_hold_multi();
        test_async_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
